// File: rtl/fifo_tt_pkg.sv
// Shared types and constants for the TT16 FIFO consumer stage:
// transmitter state encoding, default word width and frame-length helper.
package fifo_tt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int DEFAULT_DATA_WIDTH = 4;

    // Clock cycles occupied by one complete frame on the serial line.
    function automatic int frame_len(
        input int data_width,
        input int parity_en,
        input int stop_bits,
        input int clks_per_bit
    );
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts CLKS_PER_BIT cycles per serial bit and flags the
// final cycle of each bit with bit_end. clear forces the count back to zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // bit_end must not depend on clear: the top folds bit_end into its pop
    // decision, and pop feeds clear.
    assign bit_end = (cnt_q == LAST_CNT);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO consumer: pops show-ahead words and serialises each as a UART frame
// (start, data LSB-first, optional even parity, stop bits) on a registered tx.
module fifo_uart_tx
    import fifo_tt_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;

    logic bit_end;
    logic last_stop;
    logic pop;
    logic timer_clear;

    // Holding the timer clear while idle keeps it aligned to the pop edge.
    assign timer_clear = pop || (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_comb begin
        last_stop = (state_q == STOP) && bit_end && (bit_cnt_q == LAST_STOP);
        pop       = en && !empty && !rst && ((state_q == IDLE) || last_stop);
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop overrides the step above; from STOP this chains frames with
        // no idle gap.
        if (pop) begin
            state_d   = START;
            shift_d   = rdata;
            parity_d  = ^rdata;
            bit_cnt_d = '0;
        end
    end

    // tx is decoded from the next state so the registered line changes on
    // the same edge as the state it represents.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign rinc       = pop;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based show-ahead FIFO model feeds the DUT
// and a negedge line monitor checks each frame against the expected-word queue.
module tb_fifo_uart_tx;

    localparam int FRAME = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       empty;
    logic [3:0] rdata;
    logic       rinc;
    logic       tx;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (4),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .empty     (empty),
        .rdata     (rdata),
        .rinc      (rinc),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    logic [3:0] fifo_q[$];
    logic [3:0] exp_q[$];
    bit         force_empty = 1'b0;
    bit         pop_pending = 1'b0;

    int  rinc_count  = 0;
    int  frames_done = 0;
    int  idle_bad    = 0;
    int  rinc_bad    = 0;
    int  rinc_times[$];
    int  frame_starts[$];
    bit  mon_active  = 1'b0;
    bit  prev_rinc   = 1'b0;
    int  fcyc        = 0;
    int  frame_bad   = 0;
    logic [6:0] exp_bits;
    logic [3:0] mon_w;

    always @(posedge clk) cyc_n++;

    function automatic void refresh();
        empty = force_empty || (fifo_q.size() == 0);
        rdata = (fifo_q.size() != 0) ? fifo_q[0] : 4'h0;
    endfunction

    // FIFO model: a rinc seen at the negedge pops the head just after the edge.
    always @(posedge clk) begin
        if (pop_pending) begin
            #1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_pending = 1'b0;
            refresh();
        end
    end

    // Line monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            prev_rinc  = 1'b0;
            if (rinc !== 1'b0) rinc_bad++;
        end else begin
            if (prev_rinc) begin
                frame_starts.push_back(cyc_n);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: frame started with 0 expected words, required >= 1");
                    mon_active = 1'b0;
                end else begin
                    mon_w      = exp_q.pop_front();
                    exp_bits   = {1'b1, ^mon_w, mon_w, 1'b0};
                    mon_active = 1'b1;
                    fcyc       = 0;
                    frame_bad  = 0;
                end
            end
            if (mon_active) begin
                if (tx !== exp_bits[fcyc/4]) frame_bad++;
                if (frame_done !== (fcyc == FRAME - 1)) frame_bad++;
                if (busy !== 1'b1) frame_bad++;
                if (fcyc == FRAME - 1) begin
                    n_checks++;
                    if (frame_bad != 0) begin
                        n_errors++;
                        $display("FAIL frame word=%h: %0d bad cycles, required 0", mon_w, frame_bad);
                    end
                    frames_done++;
                    mon_active = 1'b0;
                end else begin
                    fcyc++;
                end
            end else if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                idle_bad++;
            end
            if (rinc === 1'b1) begin
                rinc_count++;
                rinc_times.push_back(cyc_n);
                pop_pending = 1'b1;
                if (empty !== 1'b0) rinc_bad++;
            end
            prev_rinc = (rinc === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    task automatic wait_for_rinc(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rinc === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL rinc_timeout: no rinc within %0d cycles, required one", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && rinc === 1'b0 && fifo_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, budget);
        end
    endtask

    // Samples tx mid-bit for each of the 7 bit periods following the next pop.
    task automatic capture_frame(output logic [6:0] bits, output int fd_at);
        bit ok;
        bits  = '0;
        fd_at = -1;
        wait_for_rinc(50, ok);
        if (!ok) return;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c % 4 == 2) bits[c/4] = tx;
            if (frame_done === 1'b1 && fd_at < 0) fd_at = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        refresh();
        #3;
        n_checks += 4;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (rinc !== 1'b0) begin n_errors++; $display("FAIL reset_rinc: got %b, required 0", rinc); end
        if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        int r0  = rinc_count;
        en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || rinc !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks += 2;
        if (bad != 0) begin n_errors++; $display("FAIL idle_lines: %0d bad cycles, required 0", bad); end
        if (rinc_count != r0) begin n_errors++; $display("FAIL idle_rinc: %0d pops, required 0", rinc_count - r0); end
    endtask

    task automatic test_single();
        logic [6:0] bits;
        logic [6:0] want = 7'b1110110;
        int fd_at;
        int r0 = rinc_count;
        int f0 = frames_done;
        tick();
        push_word(4'b1011);
        capture_frame(bits, fd_at);
        wait_idle(20);
        n_checks += 5;
        if (bits !== want) begin n_errors++; $display("FAIL single_bits: got %b, required %b", bits, want); end
        if (fd_at != FRAME - 1) begin n_errors++; $display("FAIL single_frame_done: at cycle %0d, required %0d", fd_at, FRAME - 1); end
        if (rinc_count - r0 != 1) begin n_errors++; $display("FAIL single_rinc: %0d pops, required 1", rinc_count - r0); end
        if (frames_done - f0 != 1) begin n_errors++; $display("FAIL single_frames: %0d, required 1", frames_done - f0); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy: got %b, required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n0 = rinc_times.size();
        int s0 = frame_starts.size();
        int f0 = frames_done;
        tick();
        push_word(4'h3);
        push_word(4'hC);
        wait_idle(120);
        n_checks += 3;
        if (rinc_times.size() - n0 != 2) begin
            n_errors++;
            $display("FAIL b2b_rinc_count: %0d pops, required 2", rinc_times.size() - n0);
        end else if (rinc_times[n0+1] - rinc_times[n0] != FRAME) begin
            n_errors++;
            $display("FAIL b2b_rinc_spacing: %0d cycles, required %0d", rinc_times[n0+1] - rinc_times[n0], FRAME);
        end
        if (frame_starts.size() - s0 != 2) begin
            n_errors++;
            $display("FAIL b2b_starts: %0d frames started, required 2", frame_starts.size() - s0);
        end else if (frame_starts[s0+1] - frame_starts[s0] != FRAME) begin
            n_errors++;
            $display("FAIL b2b_start_gap: %0d cycles, required %0d", frame_starts[s0+1] - frame_starts[s0], FRAME);
        end
        if (frames_done - f0 != 2) begin n_errors++; $display("FAIL b2b_frames: %0d, required 2", frames_done - f0); end
    endtask

    task automatic test_enable();
        bit ok;
        int r0;
        int f0 = frames_done;
        tick();
        en = 1'b0;
        push_word(4'h5);
        push_word(4'hA);
        repeat (20) @(negedge clk);
        r0 = rinc_count;
        n_checks += 2;
        if (rinc_count != 0 && rinc_times.size() != 0 && rinc_times[rinc_times.size()-1] > cyc_n - 20) begin
            n_errors++; $display("FAIL en_low_rinc: pop while en=0, required none");
        end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL en_low_busy: got %b, required 0", busy); end
        tick();
        en = 1'b1;
        wait_for_rinc(10, ok);
        repeat (5) @(negedge clk);
        tick();
        en = 1'b0;
        repeat (60) @(negedge clk);
        n_checks += 5;
        if (rinc_count - r0 != 1) begin n_errors++; $display("FAIL en_drop_rinc: %0d pops, required 1", rinc_count - r0); end
        if (frames_done - f0 != 1) begin n_errors++; $display("FAIL en_drop_frames: %0d, required 1", frames_done - f0); end
        if (fifo_q.size() != 1) begin n_errors++; $display("FAIL en_drop_fifo: %0d words left, required 1", fifo_q.size()); end
        if (tx !== 1'b1) begin n_errors++; $display("FAIL en_drop_tx: got %b, required 1", tx); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL en_drop_busy: got %b, required 0", busy); end
        tick();
        en = 1'b1;
        wait_idle(60);
        n_checks++;
        if (frames_done - f0 != 2) begin n_errors++; $display("FAIL en_resume_frames: %0d, required 2", frames_done - f0); end
    endtask

    task automatic test_interlock();
        bit ok;
        int r0 = rinc_count;
        tick();
        push_word(4'h7);
        push_word(4'h8);
        wait_for_rinc(10, ok);
        repeat (FRAME - 1) @(negedge clk);
        tick();
        force_empty = 1'b1;
        refresh();
        @(negedge clk);
        n_checks += 2;
        if (frame_done !== 1'b1) begin n_errors++; $display("FAIL lock_frame_done: got %b, required 1", frame_done); end
        if (rinc !== 1'b0) begin n_errors++; $display("FAIL lock_rinc: got %b, required 0", rinc); end
        @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL lock_busy: got %b, required 0", busy); end
        if (tx !== 1'b1) begin n_errors++; $display("FAIL lock_tx: got %b, required 1", tx); end
        tick();
        force_empty = 1'b0;
        refresh();
        wait_idle(60);
        n_checks++;
        if (rinc_count - r0 != 2) begin n_errors++; $display("FAIL lock_total_rinc: %0d pops, required 2", rinc_count - r0); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad = 0;
        logic [6:0] bits;
        logic [6:0] want = 7'b1001100;
        int fd_at;
        tick();
        push_word(4'h9);
        push_word(4'h6);
        wait_for_rinc(10, ok);
        repeat (10) @(negedge clk);
        tick();
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL rst_mid_tx: got %b, required 1", tx); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        if (rinc !== 1'b0) begin n_errors++; $display("FAIL rst_mid_rinc: got %b, required 0", rinc); end
        repeat (3) begin
            @(negedge clk);
            if (rinc !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL rst_hold: %0d bad cycles, required 0", bad); end
        tick();
        rst = 1'b0;
        capture_frame(bits, fd_at);
        wait_idle(20);
        n_checks += 2;
        if (bits !== want) begin n_errors++; $display("FAIL rst_refill_bits: got %b, required %b", bits, want); end
        if (fd_at != FRAME - 1) begin n_errors++; $display("FAIL rst_refill_done: at cycle %0d, required %0d", fd_at, FRAME - 1); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        refresh();
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_enable();
        test_interlock();
        test_reset_mid_frame();
        n_checks += 4;
        if (idle_bad != 0) begin n_errors++; $display("FAIL idle_monitor: %0d bad idle cycles, required 0", idle_bad); end
        if (rinc_bad != 0) begin n_errors++; $display("FAIL rinc_guard: %0d pops while empty or reset, required 0", rinc_bad); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left: %0d words unsent, required 0", exp_q.size()); end
        if (fifo_q.size() != 0) begin n_errors++; $display("FAIL fifo_left: %0d words unpopped, required 0", fifo_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
